// File: rtl/port_rd_scheduler_if.sv
// Handshake bundle between one output port's read scheduler and its surroundings
// (downstream ready, queue status, WRR configuration, read-engine feedback).
interface port_rd_scheduler_if #(
    parameter int PRIO_NUM = 8,
    parameter int PRIO_W   = 3,
    parameter int WT_W     = 4
);
    logic                     ready;
    logic [PRIO_NUM-1:0]      q_nonempty;
    logic                     wrr_en;
    logic [PRIO_NUM*WT_W-1:0] weights;
    logic                     pkt_done;
    logic                     sel_vld;
    logic [PRIO_W-1:0]        sel_prio;
    logic                     busy;
    logic                     ready_pend;

    modport master (
        output ready, q_nonempty, wrr_en, weights, pkt_done,
        input  sel_vld, sel_prio, busy, ready_pend
    );

    modport slave (
        input  ready, q_nonempty, wrr_en, weights, pkt_done,
        output sel_vld, sel_prio, busy, ready_pend
    );
endinterface

// File: rtl/port_rd_scheduler.sv
// Per-output-port read scheduler: picks the priority queue that supplies the next
// packet (packet-count WRR or strict priority) and tracks the packet in flight.
module port_rd_scheduler #(
    parameter int PRIO_NUM = 8,
    parameter int PRIO_W   = 3,
    parameter int WT_W     = 4
) (
    input logic               clk,
    input logic               rst,
    port_rd_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    state_t              state;
    state_t              state_next;
    logic [WT_W-1:0]     eff_wt      [PRIO_NUM];
    logic [WT_W-1:0]     credit      [PRIO_NUM];
    logic [WT_W-1:0]     cur_credit  [PRIO_NUM];
    logic [WT_W-1:0]     credit_next [PRIO_NUM];
    logic                fresh;
    logic [PRIO_NUM-1:0] eligible;
    logic [PRIO_W-1:0]   pick;
    logic [PRIO_W-1:0]   sel_prio_q;
    logic                ready_pend_q;
    logic                grant;
    logic                sel_vld;
    logic                busy;

    // While fresh is set the credits read as the current effective weights; this
    // stands in for loading eff_wt at reset and for the per-cycle reload in strict mode.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < PRIO_NUM; p++) begin
            eff_wt[p]     = (bus.weights[p*WT_W +: WT_W] == '0) ? WT_W'(1)
                                                                : bus.weights[p*WT_W +: WT_W];
            cur_credit[p] = fresh ? eff_wt[p] : credit[p];
            eligible[p]   = bus.q_nonempty[p] && (cur_credit[p] != '0);
        end
    end

    always_comb begin
        pick        = '0;
        credit_next = cur_credit;
        if (bus.wrr_en && (eligible != '0)) begin
            for (int p = 0; p < PRIO_NUM; p++) begin
                if (eligible[p]) pick = PRIO_W'(p);
            end
            credit_next[pick] = cur_credit[pick] - WT_W'(1);
        end else begin
            for (int p = 0; p < PRIO_NUM; p++) begin
                if (bus.q_nonempty[p]) pick = PRIO_W'(p);
            end
            if (bus.wrr_en) begin
                credit_next       = eff_wt;
                credit_next[pick] = eff_wt[pick] - WT_W'(1);
            end
        end
    end

    assign grant = (state == IDLE) && (bus.ready || ready_pend_q) && (bus.q_nonempty != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = GRANT;
            GRANT:   state_next = bus.pkt_done ? IDLE : BUSY;
            BUSY:    if (bus.pkt_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_vld = (state == GRANT);
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fresh <= 1'b1;
            for (int p = 0; p < PRIO_NUM; p++) credit[p] <= '0;
        end else if (!bus.wrr_en) begin
            fresh <= 1'b1;
        end else if (grant) begin
            fresh  <= 1'b0;
            credit <= credit_next;
        end
    end

    // A ready landing in the grant cycle itself survives the clear (set wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_prio_q   <= '0;
            ready_pend_q <= 1'b0;
        end else begin
            ready_pend_q <= bus.ready || (ready_pend_q && !sel_vld);
            if (grant) sel_prio_q <= pick;
        end
    end

    assign bus.sel_vld    = sel_vld;
    assign bus.busy       = busy;
    assign bus.sel_prio   = sel_prio_q;
    assign bus.ready_pend = ready_pend_q;

endmodule

// File: tb/tb_port_rd_scheduler.sv
// Directed bench for port_rd_scheduler: a cycle-level reference model checked every
// cycle, plus hand-computed expectations taken from the scheduling rules.
module tb_port_rd_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    bit   checking   = 0;

    port_rd_scheduler_if bus ();

    port_rd_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    // Reference model: whether a packet is in flight, pending request, credits as ints.
    bit m_sel    = 0;
    bit m_busy   = 0;
    bit m_pend   = 0;
    int m_prio   = 0;
    int m_credit [8];

    function automatic int effw(input logic [31:0] w, input int p);
        int v;
        v = int'((w >> (p * 4)) & 32'hF);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit grant;
        int pick;
        if (rst) begin
            m_sel  = 0;
            m_busy = 0;
            m_pend = 0;
            m_prio = 0;
            for (int p = 0; p < 8; p++) m_credit[p] = effw(bus.weights, p);
        end else begin
            grant  = !m_busy && (bus.ready || m_pend) && (bus.q_nonempty != 8'h00);
            m_pend = bus.ready || (m_pend && !m_sel);
            if (grant) begin
                pick = -1;
                if (bus.wrr_en) begin
                    for (int p = 7; p >= 0; p--)
                        if (pick < 0 && bus.q_nonempty[p] && m_credit[p] > 0) pick = p;
                    if (pick < 0) begin
                        for (int p = 0; p < 8; p++) m_credit[p] = effw(bus.weights, p);
                        for (int p = 7; p >= 0; p--)
                            if (pick < 0 && bus.q_nonempty[p]) pick = p;
                    end
                    m_credit[pick] = m_credit[pick] - 1;
                end else begin
                    for (int p = 7; p >= 0; p--)
                        if (pick < 0 && bus.q_nonempty[p]) pick = p;
                end
                m_prio = pick;
            end
            if (!bus.wrr_en)
                for (int p = 0; p < 8; p++) m_credit[p] = effw(bus.weights, p);
            if (grant) m_busy = 1;
            else if (bus.pkt_done) m_busy = 0;
            m_sel = grant;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rdy, input logic [7:0] q, input bit done, input int cycles);
        bus.ready      = rdy;
        bus.q_nonempty = q;
        bus.pkt_done   = done;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model sel_vld", int'(bus.sel_vld), int'(m_sel));
            checkOutput("model busy", int'(bus.busy), int'(m_busy));
            checkOutput("model ready_pend", int'(bus.ready_pend), int'(m_pend));
            checkOutput("model sel_prio", int'(bus.sel_prio), m_prio);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    int exp_wrr [10] = '{7, 7, 7, 3, 3, 7, 7, 7, 3, 3};

    initial begin
        rst         = 1'b1;
        bus.wrr_en  = 1'b0;
        bus.weights = 32'h0;
        checking    = 1;

        // Reset holds everything quiet even with ready and all queues active
        applyStimulus(1, 8'hFF, 0, 3);
        checkOutput("reset sel_vld", int'(bus.sel_vld), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset ready_pend", int'(bus.ready_pend), 0);
        rst = 1'b0;
        applyStimulus(1, 8'hFF, 0, 1);
        checkOutput("post-reset sel_vld", int'(bus.sel_vld), 1);
        checkOutput("post-reset sel_prio", int'(bus.sel_prio), 7);
        checkOutput("post-reset busy", int'(bus.busy), 1);
        applyStimulus(0, 8'hFF, 0, 1);
        checkOutput("grant pulse width", int'(bus.sel_vld), 0);
        checkOutput("pend consumed", int'(bus.ready_pend), 0);
        applyStimulus(0, 8'hFF, 1, 1);
        checkOutput("done clears busy", int'(bus.busy), 0);
        applyStimulus(0, 8'hFF, 0, 2);
        checkOutput("no spurious grant", int'(bus.sel_vld), 0);

        // Strict priority picks the highest nonempty queue
        applyStimulus(1, 8'b0010_1000, 0, 1);
        checkOutput("strict sel_vld", int'(bus.sel_vld), 1);
        checkOutput("strict sel_prio", int'(bus.sel_prio), 5);
        applyStimulus(0, 8'b0010_1000, 0, 29);
        checkOutput("strict busy held", int'(bus.busy), 1);
        applyStimulus(0, 8'b0010_1000, 1, 1);
        checkOutput("strict busy drop", int'(bus.busy), 0);
        applyStimulus(0, 8'b0010_1000, 0, 1);

        // pkt_done during the grant cycle returns straight to idle
        applyStimulus(1, 8'h28, 0, 1);
        applyStimulus(0, 8'h28, 1, 1);
        checkOutput("grant+done busy", int'(bus.busy), 0);
        checkOutput("grant+done sel_vld", int'(bus.sel_vld), 0);
        applyStimulus(0, 8'h28, 0, 1);

        // WRR with w7=3, w3=2, others 1
        bus.weights = 32'h3111_2111;
        applyStimulus(0, 8'h88, 0, 1);
        bus.wrr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 8'h88, 0, 1);
            checkOutput("wrr sel_vld", int'(bus.sel_vld), 1);
            checkOutput($sformatf("wrr sel_prio[%0d]", i), int'(bus.sel_prio), exp_wrr[i]);
            applyStimulus(0, 8'h88, 0, 2);
            applyStimulus(0, 8'h88, 1, 1);
            applyStimulus(0, 8'h88, 0, 1);
        end

        // A weight of zero still grants (treated as 1)
        bus.wrr_en  = 1'b0;
        bus.weights = 32'h0;
        applyStimulus(0, 8'h20, 0, 1);
        bus.wrr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'h20, 0, 1);
            checkOutput("zero-weight sel_vld", int'(bus.sel_vld), 1);
            checkOutput("zero-weight sel_prio", int'(bus.sel_prio), 5);
            applyStimulus(0, 8'h20, 0, 1);
            applyStimulus(0, 8'h20, 1, 1);
            applyStimulus(0, 8'h20, 0, 1);
        end
        bus.wrr_en = 1'b0;

        // Two ready pulses while busy coalesce into one grant at M+2
        applyStimulus(1, 8'h44, 0, 1);
        applyStimulus(0, 8'h44, 0, 2);
        applyStimulus(1, 8'h44, 0, 1);
        applyStimulus(0, 8'h44, 0, 1);
        applyStimulus(1, 8'h44, 0, 1);
        applyStimulus(0, 8'h44, 0, 2);
        checkOutput("coalesce pend", int'(bus.ready_pend), 1);
        applyStimulus(0, 8'h44, 1, 1);
        checkOutput("coalesce M+1 sel_vld", int'(bus.sel_vld), 0);
        checkOutput("coalesce M+1 busy", int'(bus.busy), 0);
        applyStimulus(0, 8'h44, 0, 1);
        checkOutput("coalesce M+2 sel_vld", int'(bus.sel_vld), 1);
        checkOutput("coalesce M+2 sel_prio", int'(bus.sel_prio), 6);
        applyStimulus(0, 8'h44, 0, 1);
        checkOutput("coalesce pend cleared", int'(bus.ready_pend), 0);
        applyStimulus(0, 8'h44, 1, 1);
        applyStimulus(0, 8'h44, 0, 3);
        checkOutput("coalesce single grant", int'(bus.busy), 0);

        // ready held into the grant cycle stays pending and earns another grant
        applyStimulus(1, 8'h10, 0, 2);
        applyStimulus(0, 8'h10, 0, 1);
        checkOutput("grant-cycle ready pend", int'(bus.ready_pend), 1);
        applyStimulus(0, 8'h10, 1, 1);
        applyStimulus(0, 8'h10, 0, 1);
        checkOutput("grant-cycle regrant", int'(bus.sel_vld), 1);
        applyStimulus(0, 8'h10, 1, 1);
        applyStimulus(0, 8'h10, 0, 2);

        // ready with nothing queued waits until a queue fills
        applyStimulus(1, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("empty sel_vld", int'(bus.sel_vld), 0);
        checkOutput("empty pend", int'(bus.ready_pend), 1);
        applyStimulus(0, 8'h00, 0, 4);
        applyStimulus(0, 8'h01, 0, 1);
        checkOutput("late queue sel_vld", int'(bus.sel_vld), 1);
        checkOutput("late queue sel_prio", int'(bus.sel_prio), 0);

        // Reset in the middle of a packet aborts at once
        applyStimulus(0, 8'h01, 1, 1);
        applyStimulus(1, 8'h02, 0, 1);
        applyStimulus(0, 8'h02, 0, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort busy", int'(bus.busy), 0);
        checkOutput("abort sel_prio", int'(bus.sel_prio), 0);
        checkOutput("abort sel_vld", int'(bus.sel_vld), 0);
        applyStimulus(0, 8'h02, 0, 1);
        rst = 1'b0;
        applyStimulus(0, 8'h02, 0, 2);
        checkOutput("abort idle", int'(bus.busy), 0);

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/port_rd_scheduler.md
Name: port_rd_scheduler

Overview:
- Per-output-port read scheduler for the 16-port hydra switch; one instance per output port.
- Selects which of the 8 priority queues of its port supplies the next packet, using packet-count weighted round robin (WRR) or strict priority.
- Waits for a downstream `ready` pulse, issues a one-cycle selection to the port read engine, then holds until that engine reports end of packet.

Parameters:
- PRIO_NUM, 8, number of priority queues per port; priority PRIO_NUM-1 is highest.
- PRIO_W, 3, width of the priority index.
- WT_W, 4, width of each WRR weight and credit counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  in  1  downstream pulse: port may emit one packet.
- q_nonempty  in  PRIO_NUM  bit p=1 when priority queue p holds at least one complete packet.
- wrr_en  in  1  1 = WRR, 0 = strict priority.
- weights  in  PRIO_NUM*WT_W  packets per round; weight p at bits [p*WT_W +: WT_W].
- pkt_done  in  1  pulse from the read engine on the cycle rd_eop is driven.
- sel_vld  out  1  one-cycle pulse: start reading the queue given by sel_prio.
- sel_prio  out  PRIO_W  selected priority, valid when sel_vld=1, held until the next selection.
- busy  out  1  high from sel_vld until pkt_done.
- ready_pend  out  1  a `ready` has been latched but not yet consumed.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; sel_vld=0, sel_prio=0, busy=0, ready_pend=0; credit[p]=eff_wt[p] for all p.
- Effective weight: eff_wt[p] = weights[p], except a weight of 0 is treated as 1.
- ready_pend handling:
  - Set on any cycle with ready=1, in any state.
  - Cleared on the cycle sel_vld is registered.
  - ready arriving on that same cycle keeps ready_pend=1 (set wins).
  - Multiple ready pulses coalesce into one pending request.
- State IDLE: let req = ready | ready_pend. If req=1 and q_nonempty≠0, run selection. The next cycle has sel_vld=1, busy=1 and state GRANT. Otherwise stay in IDLE.
- State GRANT (exactly 1 cycle): sel_vld drops to 0 and the state moves to BUSY. If pkt_done=1 in this cycle, go directly to IDLE with busy=0.
- State BUSY: wait for pkt_done=1, then next cycle busy=0 and state IDLE.
- pkt_done seen in IDLE is ignored.
- Latency: ready at cycle N with a queue nonempty gives sel_vld at N+1. Back-to-back: pkt_done at cycle M with ready_pend=1 gives the earliest next sel_vld at M+2.
- Strict selection (wrr_en=0):
  - Pick the highest p with q_nonempty[p]=1.
  - Credits are forced to eff_wt every cycle, so enabling WRR starts a fresh round.
- WRR selection (wrr_en=1):
  - eligible[p] = q_nonempty[p] & (credit[p]≠0).
  - If eligible≠0, pick the highest eligible p and decrement credit[p] by 1.
  - Otherwise reload every credit to eff_wt, pick the highest nonempty p, and set credit[p]=eff_wt[p]-1.
  - Credits never wrap below 0.
- Changes to weights take effect only at the next reload. wrr_en is sampled at each selection.
- Queue emptiness is sampled only at selection; the read engine guarantees the selected queue is not drained by another agent.
- Reset mid-packet aborts immediately to IDLE with outputs at reset values.

Test Plan:
- Reset with ready=1 and q_nonempty=8'hFF -> sel_vld=0, busy=0, ready_pend=0 while rst=1; sel_vld=1 one cycle after rst is released (ready still high).
- wrr_en=0, q_nonempty=8'b0010_1000, ready pulse at cycle 10 -> sel_vld=1 at cycle 11 with sel_prio=5; pkt_done at cycle 40 -> busy=0 at cycle 41.
- wrr_en=1, weights all 1 except w[7]=3, w[3]=2, q_nonempty=8'h88 constant, ready re-pulsed after each pkt_done -> sel_prio sequence 7,7,7,3,3,7,7,7,3,3.
- wrr_en=1, weights[5]=0, q_nonempty=8'h20 -> every grant has sel_prio=5; a weight of 0 is treated as 1, so there is no deadlock.
- ready pulsed twice during BUSY, pkt_done at cycle M -> exactly one sel_vld, at M+2; ready_pend=0 afterwards.
- ready pulse with q_nonempty=0 -> no sel_vld, ready_pend=1. q_nonempty=8'h01 five cycles later -> sel_vld next cycle with sel_prio=0.
